// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes, skid-buffer occupancy encoding and XLEN legality check
package imm_pkg;
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;
   localparam logic [2:0] IMM_Z = 3'b101;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
   function automatic bit xlen_ok(int x);
      return x == 32 || x == 64;
   endfunction
endpackage

// File: rtl/imm_format.sv
// imm_format: combinational RV32I/zimm immediate extractor, sign-extended to XLEN
module imm_format
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [24:0]     instr,
   input  logic [2:0]      src,
   output logic [XLEN-1:0] ext,
   output logic            err
);
   if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("imm_format: XLEN must be 32 or 64");
   end
   logic        s;
   logic [31:0] v;
   assign s = instr[24];
   // instr[k] is instruction bit k+7; build a 32-bit value then sign-extend it to XLEN
   always_comb begin
      v = src == IMM_I ? {{20{s}}, instr[24:13]} :
          src == IMM_S ? {{20{s}}, instr[24:18], instr[4:0]} :
          src == IMM_B ? {{19{s}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0} :
          src == IMM_J ? {{11{s}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0} :
          src == IMM_U ? {instr[24:5], 12'b0} :
          src == IMM_Z ? {27'b0, instr[12:8]} : '0;
      err = src[2] & src[1];
      ext = XLEN'(signed'(v));
   end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate generation behind a 2-entry skid buffer
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic             ImmErr,
   output logic [TAG_W-1:0] out_tag
);
   localparam int EW = XLEN + 1 + TAG_W;
   if (TAG_W < 1) begin : g_bad_tag
      $error("imm_decode_stage: TAG_W must be at least 1");
   end
   occ_t            state, nxt;
   logic [EW-1:0]   head, skid, ent;
   logic [XLEN-1:0] ext;
   logic            err, acc, pop;
   imm_format #(.XLEN(XLEN)) u_fmt (
      .instr(Instr),
      .src  (ImmSrc),
      .ext  (ext),
      .err  (err)
   );
   assign ent = {ext, err, in_tag};
   assign acc = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   assign {ImmExt, ImmErr, out_tag} = head;
   // occupancy next state; flush empties the buffer whatever else happens
   always_comb begin
      nxt = flush          ? EMPTY :
            state == EMPTY ? (acc ? ONE : EMPTY) :
            state == ONE   ? (acc && !pop ? TWO : pop && !acc ? EMPTY : ONE) :
                             (pop ? ONE : TWO);
   end
   // state and handshake flags, registered so in_ready never sees out_ready combinationally
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= nxt;
         in_ready  <= nxt != TWO;
         out_valid <= nxt != EMPTY;
      end
   end
   // head loads a new entry when empty or replaced, else the skid entry on a pop from TWO
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         skid <= '0;
      end else if (!flush) begin
         if (acc && (state == EMPTY || pop)) head <= ent;
         else if (pop && state == TWO) head <= skid;
         if (acc && state == ONE && !pop) skid <= ent;
      end
   end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: random and directed checks of both XLEN variants against a queue model
module tb_imm_decode_stage;
   logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] word = 0;
   logic [2:0]  src = 0;
   logic [4:0]  tag = 0;
   logic        rdy32, rdy64, vld32, vld64, err32, err64;
   logic [31:0] ext32;
   logic [63:0] ext64;
   logic [4:0]  tag32, tag64;
   int          checks = 0, failures = 0;
   bit          armed = 0;
   typedef struct {logic [63:0] v; logic e; logic [4:0] t;} ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .TAG_W(5)) d32 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .Instr(word[31:7]), .ImmSrc(src), .in_tag(tag), .out_valid(vld32), .out_ready(out_ready),
      .ImmExt(ext32), .ImmErr(err32), .out_tag(tag32));
   imm_decode_stage #(.XLEN(64), .TAG_W(5)) d64 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .Instr(word[31:7]), .ImmSrc(src), .in_tag(tag), .out_valid(vld64), .out_ready(out_ready),
      .ImmExt(ext64), .ImmErr(err64), .out_tag(tag64));

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   // immediate value from the full instruction word using signed arithmetic on a 64-bit integer
   function automatic ent_t model(input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
      longint x;
      ent_t   r;
      x   = longint'(signed'(w));
      r.e = 1'b0;
      r.t = t;
      case (s)
         3'd0: r.v = x >>> 20;
         3'd1: r.v = ((x >>> 25) <<< 5) | ((x >> 7) & 31);
         3'd2: r.v = ((x >>> 31) <<< 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
         3'd3: r.v = ((x >>> 31) <<< 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
         3'd4: r.v = x & ~longint'(4095);
         3'd5: r.v = (x >> 15) & 31;
         default: begin r.v = 0; r.e = 1'b1; end
      endcase
      return r;
   endfunction

   // reference occupancy: a FIFO of at most two entries
   always @(posedge clk) begin
      bit acc, pop;
      acc = in_valid && q.size() < 2;
      pop = q.size() > 0 && out_ready;
      if (reset || flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(model(word, src, tag));
      end
   end

   // every-cycle comparison against the reference
   always @(negedge clk) if (armed) begin
      chk("in_ready32", rdy32, q.size() < 2);
      chk("in_ready64", rdy64, q.size() < 2);
      chk("out_valid32", vld32, q.size() > 0);
      chk("out_valid64", vld64, q.size() > 0);
      if (q.size() > 0) begin
         chk("ext32", ext32, q[0].v[31:0]);
         chk("ext64", ext64, q[0].v);
         chk("err32", err32, q[0].e);
         chk("err64", err64, q[0].e);
         chk("tag32", tag32, q[0].t);
         chk("tag64", tag64, q[0].t);
      end
   end

   task automatic one(input string n, input logic [31:0] w, input logic [2:0] s, input logic [4:0] t,
                      input logic [63:0] e64, input logic e);
      word = w; src = s; tag = t; in_valid = 1; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      chk({n, "_vld"}, vld64, 1);
      chk({n, "_ext32"}, ext32, e64[31:0]);
      chk({n, "_ext64"}, ext64, e64);
      chk({n, "_err"}, err64, e);
      chk({n, "_tag"}, tag64, t);
      @(negedge clk);
   endtask

   initial begin
      ent_t m;
      m = model(32'hFFF00093, 3'd0, 5'd0); chk("pin_addi", m.v, 64'hFFFFFFFFFFFFFFFF);
      m = model(32'hFE112E23, 3'd1, 5'd0); chk("pin_sw", m.v, 64'hFFFFFFFFFFFFFFFC);
      m = model(32'hFE000EE3, 3'd2, 5'd0); chk("pin_beq", m.v, 64'hFFFFFFFFFFFFFFFC);
      m = model(32'hFF9FF06F, 3'd3, 5'd0); chk("pin_jal", m.v, 64'hFFFFFFFFFFFFFFF8);
      m = model(32'h123452B7, 3'd4, 5'd0); chk("pin_lui", m.v, 64'h12345000);
      m = model(32'h000F8000, 3'd5, 5'd0); chk("pin_zimm", m.v, 64'h1F);
      @(negedge clk);
      armed = 1;
      @(negedge clk);
      reset = 0;
      chk("rst_ready", rdy64, 1);
      chk("rst_valid", vld64, 0);
      chk("rst_ext", ext64, 0);
      chk("rst_err", err64, 0);
      chk("rst_tag", tag64, 0);
      one("addi", 32'hFFF00093, 3'd0, 5'd1, 64'hFFFFFFFFFFFFFFFF, 0);
      one("sw",   32'hFE112E23, 3'd1, 5'd2, 64'hFFFFFFFFFFFFFFFC, 0);
      one("beq",  32'hFE000EE3, 3'd2, 5'd6, 64'hFFFFFFFFFFFFFFFC, 0);
      one("jal",  32'hFF9FF06F, 3'd3, 5'd3, 64'hFFFFFFFFFFFFFFF8, 0);
      one("lui",  32'h123452B7, 3'd4, 5'd4, 64'h12345000, 0);
      one("zimm", 32'h000F8000, 3'd5, 5'd5, 64'h1F, 0);
      one("bad",  32'hFFFFFFFF, 3'd6, 5'd9, 64'h0, 1);
      out_ready = 0; word = 32'hFFF00093; src = 3'd0; in_valid = 1; tag = 5'd1;
      @(negedge clk); chk("bp_rdy1", rdy32, 1);
      tag = 5'd2;
      @(negedge clk); chk("bp_rdy2", rdy32, 0); chk("bp_head1", tag32, 1);
      tag = 5'd3;
      @(negedge clk); chk("bp_hold", rdy32, 0); chk("bp_head1b", tag32, 1);
      out_ready = 1;
      @(negedge clk); chk("bp_head2", tag32, 2); chk("bp_rdy3", rdy32, 1);
      @(negedge clk); in_valid = 0; chk("bp_head3", tag32, 3); chk("bp_vld3", vld32, 1);
      @(negedge clk); chk("bp_empty", vld32, 0);
      out_ready = 0; in_valid = 1; tag = 5'd4;
      @(negedge clk); tag = 5'd5;
      @(negedge clk); tag = 5'd6; flush = 1;
      @(negedge clk); flush = 0; in_valid = 0;
      chk("fl_vld", vld32, 0); chk("fl_rdy", rdy32, 1);
      out_ready = 1;
      repeat (3) begin
         @(negedge clk); chk("fl_none", vld64, 0);
      end
      out_ready = 0; in_valid = 1; tag = 5'd7; word = 32'h123452B7; src = 3'd4;
      @(negedge clk); reset = 1; tag = 5'd8;
      @(negedge clk); reset = 0; in_valid = 0;
      chk("rst2_vld", vld64, 0); chk("rst2_rdy", rdy64, 1);
      chk("rst2_ext", ext64, 0); chk("rst2_err", err64, 0); chk("rst2_tag", tag64, 0);
      one("post_rst", 32'hFFF00093, 3'd0, 5'd8, 64'hFFFFFFFFFFFFFFFF, 0);
      for (int i = 0; i < 3000; i++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 40) == 0;
         reset     = $urandom_range(0, 150) == 0;
         word      = $urandom;
         src       = 3'($urandom_range(0, 7));
         tag       = 5'($urandom);
         @(negedge clk);
      end
      reset = 0; flush = 0; in_valid = 0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised, registered immediate-generation stage for the decode path of the 5-stage RISC-V core. It extracts and sign-extends the immediate from an instruction word for all RV32I formats plus CSR zimm, to a configurable XLEN. Results go through a 2-entry skid buffer with valid/ready handshakes on both sides, plus a flush input. It replaces the purely combinational extender, so the decode→execute boundary can stall and flush without recomputation.

## Interface
Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills all upper bits.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd or ROB index); minimum 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  producer presents Instr/ImmSrc/in_tag.
- in_ready  out  1  stage can accept this cycle.
- Instr  in  25  instruction bits [31:7].
- ImmSrc  in  3  format select (see Operation).
- in_tag  in  TAG_W  sideband, travels with entry.
- out_valid  out  1  ImmExt/ImmErr/out_tag valid.
- out_ready  in  1  consumer accepts this cycle.
- ImmExt  out  XLEN  extended immediate.
- ImmErr  out  1  entry had an illegal ImmSrc.
- out_tag  out  TAG_W  tag of head entry.

## Operation
- ImmSrc encoding: 000 I = sext(Instr[31:20]); 001 S = sext({Instr[31:25],Instr[11:7]}); 010 B = sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}); 011 J = sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}); 100 U = sext({Instr[31:12],12'b0}); 101 Z = zext(Instr[19:15]); 110/111 illegal → ImmExt 0, ImmErr 1.
- Codes 000–011 are bit-identical to the previous 2-bit extender's values at XLEN=32.
- Immediate is computed at accept time and stored; buffer holds {ImmExt, ImmErr, tag}.
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- FIFO order strictly preserved.
- Occupancy FSM EMPTY/ONE/TWO:
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → TWO; pop & !accept → EMPTY; both → ONE, head replaced by new entry.
  - TWO: pop → ONE, skid entry moves to head; no accept possible.
- in_ready = (state != TWO), driven from a register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY); outputs always reflect the head register.
- flush: next state EMPTY regardless of accept/pop in the same cycle; in_valid in the flush cycle is dropped. Data registers are not cleared.
- reset: state EMPTY, in_ready 1, out_valid 0, ImmExt 0, ImmErr 0, out_tag 0.
- reset has priority over flush; flush has priority over accept/pop.

## Timing
- Latency: accept in cycle N into EMPTY → out_valid, ImmExt in cycle N+1.
- Throughput: 1 entry/cycle when out_ready held high.
- Back-pressure: with out_ready low, two accepts fill the buffer; in_ready falls in the cycle after the second accept.
- After a pop from TWO, in_ready rises the following cycle.
- When out_valid=0, ImmExt/ImmErr/out_tag hold their last values (0 after reset); the bench checks them only when out_valid=1.
- Reset or flush asserted mid-stream: out_valid=0 and in_ready=1 in the next cycle. No entry accepted before the flush ever appears at the output.

## Structure
- Package imm_pkg holds the ImmSrc constants (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z), the occupancy state encoding, and the XLEN legality check.
- Sub-module imm_format is the combinational Instr/ImmSrc → {ImmExt, ImmErr} extractor parametrised by XLEN. Instantiate it once on the input side.
- Top level holds only the FSM and the two entry registers.

## Test plan
- XLEN=32, single accept, out_ready=1:
  - Instr=0xFFF00093>>7 (addi x1,x0,-1), ImmSrc=000 → next cycle ImmExt=0xFFFFFFFF, ImmErr=0.
  - 0xFE112E23 (sw x1,-4(x2)), ImmSrc=001 → 0xFFFFFFFC.
  - 0xFF9FF06F (jal x0,-8), ImmSrc=011 → 0xFFFFFFF8.
  - 0x123452B7 (lui), ImmSrc=100 → 0x12345000.
- XLEN=64: the same sw → 0xFFFFFFFF_FFFFFFFC. ImmSrc=101 with Instr[19:15]=5'h1F → 0x1F, zero-extended.
- Illegal format: ImmSrc=110 → ImmExt=0, ImmErr=1, tag preserved.
- Back-pressure: out_ready=0, three consecutive in_valid with tags 1,2,3 → tags 1,2 accepted, in_ready=0, tag 3 held. Raise out_ready → outputs 1,2,3 in order, no loss or duplication.
- Flush with buffer in TWO and in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three entries ever emerge.
- Reset asserted during a stream → all outputs at reset values next cycle. First accept after reset completes with 1-cycle latency.
